mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle control unit that sequences the shared datapath (PC, IR, register file, the single ALU, unified memory port) through fetch, decode, execute, memory and writeback phases, one instruction at a time. Sits beside the datapath in the core top level and drives every enable and mux select. It owns the ALU's opcode input and the branch decision, and optionally carries performance counters.

## Interface
- `DATA_WIDTH`, 32, width of the performance counters (same constant as the datapath).
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `opcode_i`  in  `opcode`  decoded IR opcode field (package enum).
- `funct3_i`  in  3  IR funct3.
- `is_zero_i`, `is_less_i`  in  1 each  ALU compare flags, valid combinationally during EXECUTE.
- `mem_ready_i`  in  1  memory accepted write / returned read data this cycle.
- `mem_req_o`  out  1  memory access request; `mem_we_o`  out  1  write when high.
- `iord_o`  out  1  memory address from ALU-out register (1) or PC (0).
- `pc_we_o`, `ir_we_o`, `rf_we_o`, `aluout_we_o`, `mdr_we_o`  out  1 each  register write strobes.
- `pc_sel_o`  out  `pc_sel_e`  PC source: ALU_RESULT / ALU_OUT_REG.
- `alu_a_sel_o`  out  `alu_a_sel_e`  PC / OLD_PC / RS1 / ZERO.
- `alu_b_sel_o`  out  `alu_b_sel_e`  RS2 / IMM / FOUR.
- `alu_opcode_o`  out  `opcode`  opcode presented to the ALU.
- `wb_sel_o`  out  `wb_sel_e`  ALU_OUT_REG / MDR / PC.
- `trap_o`  out  1  illegal opcode seen; sticky.
- `cycle_cnt_o`, `instret_cnt_o`  out  `DATA_WIDTH`  counters (only with macro).

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, MEM_WB, WRITEBACK, TRAP. Outputs are Moore decode of the state plus `mem_ready_i`/flags where noted; unlisted outputs are 0.
- IDLE: all outputs 0; entered on reset; next state FETCH unconditionally.
- FETCH: `mem_req_o`=1, `iord_o`=0, ALU computes PC+4 (a=PC, b=FOUR, alu_opcode=LOAD). Hold until `mem_ready_i`; in that cycle `ir_we_o`=`pc_we_o`=1, `pc_sel_o`=ALU_RESULT; go DECODE.
- DECODE: ALU computes OLD_PC+IMM into ALU-out (`aluout_we_o`=1, alu_opcode=LOAD). Opcode outside {R, IMMEDIATE, LOAD, STORE, JAL, LUI, AUIPC, BRANCH} -> TRAP; else EXECUTE.
- EXECUTE: R: a=RS1,b=RS2; IMMEDIATE/LOAD/STORE: a=RS1,b=IMM; LUI: a=ZERO,b=IMM; AUIPC: a=OLD_PC,b=IMM; `alu_opcode_o`=`opcode_i`, `aluout_we_o`=1. BRANCH: a=RS1,b=RS2, alu_opcode=R with funct7 path sub; taken per funct3 000 zero, 001 !zero, 100 less, 101 !less, other funct3 -> TRAP; taken -> `pc_we_o`=1, `pc_sel_o`=ALU_OUT_REG; next FETCH. JAL: `rf_we_o`=1, `wb_sel_o`=PC, `pc_we_o`=1, `pc_sel_o`=ALU_OUT_REG; next FETCH. LOAD/STORE -> MEM; others -> WRITEBACK.
- MEM: `mem_req_o`=1, `iord_o`=1, `mem_we_o`=STORE. Hold until `mem_ready_i`; LOAD: `mdr_we_o`=1, next MEM_WB; STORE: next FETCH.
- MEM_WB: `rf_we_o`=1, `wb_sel_o`=MDR; next FETCH. WRITEBACK: `rf_we_o`=1, `wb_sel_o`=ALU_OUT_REG; next FETCH.
- TRAP: `trap_o`=1, all strobes 0; left only by reset.
- Instruction retires on the last cycle before returning to FETCH.

## Timing
- Reset: state IDLE, all outputs 0, `trap_o`=0, counters 0; asynchronous assert, synchronous-to-clock release; reset mid-access drops `mem_req_o` immediately.
- Latency with zero wait states: ALU/LUI/AUIPC 4 cycles, BRANCH/JAL 3, STORE 4, LOAD 5; each `mem_ready_i`-low cycle adds 1.
- `mem_req_o` and address/we stay stable from first request cycle until the `mem_ready_i` cycle; `mem_ready_i` while `mem_req_o`=0 is ignored.

## Configuration
- `MC_PERF_COUNTERS_EN` defined: `cycle_cnt_o` increments every cycle out of reset (including TRAP), `instret_cnt_o` on each retire; both wrap modulo 2^DATA_WIDTH.
- Undefined: counter ports present, tied to 0, no flops.

## Structure
- Package: `opcode` enum (add BRANCH), `pc_sel_e`, `alu_a_sel_e`, `alu_b_sel_e`, `wb_sel_e`, `mc_state_e`, funct3 branch constants.
- One sub-module `mc_branch_cond` (funct3, flags -> taken, illegal).

## Test plan
- Reset released, `mem_ready_i`=1, IR=ADD (R, f3=000): IDLE,FETCH,DECODE,EXECUTE,WRITEBACK; `rf_we_o` at cycle 5, `wb_sel_o`=ALU_OUT_REG.
- LOAD with `mem_ready_i` low 3 cycles in MEM -> `mem_req_o`,`iord_o` held 4 cycles, `mdr_we_o` once, `rf_we_o` with `wb_sel_o`=MDR next cycle.
- BEQ, `is_zero_i`=1 -> `pc_we_o`,`pc_sel_o`=ALU_OUT_REG in EXECUTE; `is_zero_i`=0 -> no `pc_we_o`, FETCH next.
- BRANCH f3=010 or undefined opcode -> `trap_o`=1 sticky, no strobes for 20 cycles; reset clears.
- `rst_ni` low during FETCH wait -> `mem_req_o` 0 same cycle; restart from IDLE.
- With `MC_PERF_COUNTERS_EN`: 10 ADDs zero-wait -> `instret_cnt_o`=10, `cycle_cnt_o`=41; preload near 2^32-1 -> wraps to 0.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared types for the multi-cycle control unit: opcodes, datapath mux selects,
// FSM state encodings and the branch funct3 codes.
package mc_control_fsm_pkg;

  typedef enum logic [6:0] {
    OP_NONE      = 7'b0000000,
    OP_LOAD      = 7'b0000011,
    OP_IMMEDIATE = 7'b0010011,
    OP_AUIPC     = 7'b0010111,
    OP_STORE     = 7'b0100011,
    OP_R         = 7'b0110011,
    OP_LUI       = 7'b0110111,
    OP_BRANCH    = 7'b1100011,
    OP_JAL       = 7'b1101111
  } opcode;

  typedef enum logic {
    PC_SEL_ALU_RESULT  = 1'b0,
    PC_SEL_ALU_OUT_REG = 1'b1
  } pc_sel_e;

  typedef enum logic [1:0] {
    ALU_A_PC     = 2'd0,
    ALU_A_OLD_PC = 2'd1,
    ALU_A_RS1    = 2'd2,
    ALU_A_ZERO   = 2'd3
  } alu_a_sel_e;

  typedef enum logic [1:0] {
    ALU_B_RS2  = 2'd0,
    ALU_B_IMM  = 2'd1,
    ALU_B_FOUR = 2'd2
  } alu_b_sel_e;

  typedef enum logic [1:0] {
    WB_ALU_OUT_REG = 2'd0,
    WB_MDR         = 2'd1,
    WB_PC          = 2'd2
  } wb_sel_e;

  // State codes stay plain vectors so existing debug tooling can decode them.
  typedef logic [2:0] mc_state_e;
  localparam mc_state_e ST_IDLE      = 3'd0;
  localparam mc_state_e ST_FETCH     = 3'd1;
  localparam mc_state_e ST_DECODE    = 3'd2;
  localparam mc_state_e ST_EXECUTE   = 3'd3;
  localparam mc_state_e ST_MEM       = 3'd4;
  localparam mc_state_e ST_MEM_WB    = 3'd5;
  localparam mc_state_e ST_WRITEBACK = 3'd6;
  localparam mc_state_e ST_TRAP      = 3'd7;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control/status bundle between the control FSM (master) and the datapath (slave).
interface mc_control_fsm_if;
  import mc_control_fsm_pkg::*;

  opcode      opcode_i;
  logic [2:0] funct3_i;
  logic       is_zero_i;
  logic       is_less_i;
  logic       mem_ready_i;

  logic       mem_req_o;
  logic       mem_we_o;
  logic       iord_o;
  logic       pc_we_o;
  logic       ir_we_o;
  logic       rf_we_o;
  logic       aluout_we_o;
  logic       mdr_we_o;
  pc_sel_e    pc_sel_o;
  alu_a_sel_e alu_a_sel_o;
  alu_b_sel_e alu_b_sel_o;
  opcode      alu_opcode_o;
  wb_sel_e    wb_sel_o;

  modport master (
    input  opcode_i, funct3_i, is_zero_i, is_less_i, mem_ready_i,
    output mem_req_o, mem_we_o, iord_o, pc_we_o, ir_we_o, rf_we_o,
           aluout_we_o, mdr_we_o, pc_sel_o, alu_a_sel_o, alu_b_sel_o,
           alu_opcode_o, wb_sel_o
  );

  modport slave (
    output opcode_i, funct3_i, is_zero_i, is_less_i, mem_ready_i,
    input  mem_req_o, mem_we_o, iord_o, pc_we_o, ir_we_o, rf_we_o,
           aluout_we_o, mdr_we_o, pc_sel_o, alu_a_sel_o, alu_b_sel_o,
           alu_opcode_o, wb_sel_o
  );

endinterface

// File: rtl/mc_branch_cond.sv
// Branch decision from funct3 and the ALU compare flags; flags unsupported funct3.
module mc_branch_cond
  import mc_control_fsm_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       is_zero,
  input  logic       is_less,
  output logic       taken,
  output logic       illegal
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = is_zero;
      F3_BNE:  taken = !is_zero;
      F3_BLT:  taken = is_less;
      F3_BGE:  taken = !is_less;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM: fetch/decode/execute/mem/writeback sequencing of the datapath.
// Define MC_PERF_COUNTERS_EN to build the cycle and retired-instruction counters.
module mc_control_fsm
  import mc_control_fsm_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  mc_control_fsm_if.master      ctl,
  output logic                  trap_o,
  output logic [DATA_WIDTH-1:0] cycle_cnt_o,
  output logic [DATA_WIDTH-1:0] instret_cnt_o
);

  mc_state_e state_q;
  mc_state_e state_d;
  logic      br_taken;
  logic      br_illegal;

  mc_branch_cond u_branch_cond (
    .funct3  (ctl.funct3_i),
    .is_zero (ctl.is_zero_i),
    .is_less (ctl.is_less_i),
    .taken   (br_taken),
    .illegal (br_illegal)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  assign trap_o = (state_q == ST_TRAP);

  always_comb begin
    state_d          = state_q;
    ctl.mem_req_o    = 1'b0;
    ctl.mem_we_o     = 1'b0;
    ctl.iord_o       = 1'b0;
    ctl.pc_we_o      = 1'b0;
    ctl.ir_we_o      = 1'b0;
    ctl.rf_we_o      = 1'b0;
    ctl.aluout_we_o  = 1'b0;
    ctl.mdr_we_o     = 1'b0;
    ctl.pc_sel_o     = PC_SEL_ALU_RESULT;
    ctl.alu_a_sel_o  = ALU_A_PC;
    ctl.alu_b_sel_o  = ALU_B_RS2;
    ctl.alu_opcode_o = OP_NONE;
    ctl.wb_sel_o     = WB_ALU_OUT_REG;

    case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        ctl.mem_req_o    = 1'b1;
        ctl.alu_a_sel_o  = ALU_A_PC;
        ctl.alu_b_sel_o  = ALU_B_FOUR;
        ctl.alu_opcode_o = OP_LOAD;
        if (ctl.mem_ready_i) begin
          ctl.ir_we_o  = 1'b1;
          ctl.pc_we_o  = 1'b1;
          ctl.pc_sel_o = PC_SEL_ALU_RESULT;
          state_d      = ST_DECODE;
        end
      end

      // Branch/jump target is precomputed here so EXECUTE can redirect the PC.
      ST_DECODE: begin
        ctl.aluout_we_o  = 1'b1;
        ctl.alu_a_sel_o  = ALU_A_OLD_PC;
        ctl.alu_b_sel_o  = ALU_B_IMM;
        ctl.alu_opcode_o = OP_LOAD;
        case (ctl.opcode_i)
          OP_R, OP_IMMEDIATE, OP_LOAD, OP_STORE,
          OP_JAL, OP_LUI, OP_AUIPC, OP_BRANCH: state_d = ST_EXECUTE;
          default:                             state_d = ST_TRAP;
        endcase
      end

      ST_EXECUTE: begin
        ctl.alu_opcode_o = ctl.opcode_i;
        case (ctl.opcode_i)
          OP_R: begin
            ctl.alu_a_sel_o = ALU_A_RS1;
            ctl.alu_b_sel_o = ALU_B_RS2;
            ctl.aluout_we_o = 1'b1;
            state_d         = ST_WRITEBACK;
          end
          OP_IMMEDIATE: begin
            ctl.alu_a_sel_o = ALU_A_RS1;
            ctl.alu_b_sel_o = ALU_B_IMM;
            ctl.aluout_we_o = 1'b1;
            state_d         = ST_WRITEBACK;
          end
          OP_LOAD, OP_STORE: begin
            ctl.alu_a_sel_o = ALU_A_RS1;
            ctl.alu_b_sel_o = ALU_B_IMM;
            ctl.aluout_we_o = 1'b1;
            state_d         = ST_MEM;
          end
          OP_LUI: begin
            ctl.alu_a_sel_o = ALU_A_ZERO;
            ctl.alu_b_sel_o = ALU_B_IMM;
            ctl.aluout_we_o = 1'b1;
            state_d         = ST_WRITEBACK;
          end
          OP_AUIPC: begin
            ctl.alu_a_sel_o = ALU_A_OLD_PC;
            ctl.alu_b_sel_o = ALU_B_IMM;
            ctl.aluout_we_o = 1'b1;
            state_d         = ST_WRITEBACK;
          end
          // The ALU runs its R-type subtract to produce the compare flags.
          OP_BRANCH: begin
            ctl.alu_a_sel_o  = ALU_A_RS1;
            ctl.alu_b_sel_o  = ALU_B_RS2;
            ctl.alu_opcode_o = OP_R;
            if (br_illegal) begin
              state_d = ST_TRAP;
            end else begin
              ctl.pc_we_o  = br_taken;
              ctl.pc_sel_o = PC_SEL_ALU_OUT_REG;
              state_d      = ST_FETCH;
            end
          end
          OP_JAL: begin
            ctl.rf_we_o  = 1'b1;
            ctl.wb_sel_o = WB_PC;
            ctl.pc_we_o  = 1'b1;
            ctl.pc_sel_o = PC_SEL_ALU_OUT_REG;
            state_d      = ST_FETCH;
          end
          default: state_d = ST_TRAP;
        endcase
      end

      ST_MEM: begin
        ctl.mem_req_o = 1'b1;
        ctl.iord_o    = 1'b1;
        ctl.mem_we_o  = (ctl.opcode_i == OP_STORE);
        if (ctl.mem_ready_i) begin
          if (ctl.opcode_i == OP_LOAD) begin
            ctl.mdr_we_o = 1'b1;
            state_d      = ST_MEM_WB;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end

      ST_MEM_WB: begin
        ctl.rf_we_o  = 1'b1;
        ctl.wb_sel_o = WB_MDR;
        state_d      = ST_FETCH;
      end

      ST_WRITEBACK: begin
        ctl.rf_we_o  = 1'b1;
        ctl.wb_sel_o = WB_ALU_OUT_REG;
        state_d      = ST_FETCH;
      end

      ST_TRAP: state_d = ST_TRAP;

      default: state_d = ST_IDLE;
    endcase
  end

`ifdef MC_PERF_COUNTERS_EN
  logic [DATA_WIDTH-1:0] cycle_cnt_q;
  logic [DATA_WIDTH-1:0] instret_cnt_q;
  logic                  retire;

  // Any return to FETCH from a post-fetch state marks the end of an instruction.
  assign retire = (state_d == ST_FETCH) && (state_q != ST_FETCH) && (state_q != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + DATA_WIDTH'(1);
      if (retire) instret_cnt_q <= instret_cnt_q + DATA_WIDTH'(1);
    end
  end

  assign cycle_cnt_o   = cycle_cnt_q;
  assign instret_cnt_o = instret_cnt_q;
`else
  assign cycle_cnt_o   = '0;
  assign instret_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle strobe/select checks for each instruction class.
module tb_mc_control_fsm;
  import mc_control_fsm_pkg::*;

  localparam int DATA_WIDTH = 32;

  // Strobe vector order: {pc_we, ir_we, rf_we, aluout_we, mdr_we, mem_req, mem_we}
  localparam logic [6:0] S_NONE    = 7'b0000000;
  localparam logic [6:0] S_FETCH   = 7'b1100010;
  localparam logic [6:0] S_FWAIT   = 7'b0000010;
  localparam logic [6:0] S_ALUOUT  = 7'b0001000;
  localparam logic [6:0] S_RFWE    = 7'b0010000;
  localparam logic [6:0] S_MEMRD   = 7'b0000010;
  localparam logic [6:0] S_MEMRDY  = 7'b0000110;
  localparam logic [6:0] S_MEMWR   = 7'b0000011;
  localparam logic [6:0] S_BRTAKEN = 7'b1000000;
  localparam logic [6:0] S_JAL     = 7'b1010000;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  trap_o;
  logic [DATA_WIDTH-1:0] cycle_cnt_o;
  logic [DATA_WIDTH-1:0] instret_cnt_o;
  int                    n_cmp = 0;
  int                    n_err = 0;

  mc_control_fsm_if bus ();

  mc_control_fsm #(.DATA_WIDTH(DATA_WIDTH)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .ctl           (bus),
    .trap_o        (trap_o),
    .cycle_cnt_o   (cycle_cnt_o),
    .instret_cnt_o (instret_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {bus.pc_we_o, bus.ir_we_o, bus.rf_we_o, bus.aluout_we_o,
            bus.mdr_we_o, bus.mem_req_o, bus.mem_we_o};
  endfunction

  // Move to just after the next rising edge; callers set inputs, then settle with #1.
  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    bus.opcode_i    = OP_NONE;
    bus.funct3_i    = 3'b000;
    bus.is_zero_i   = 1'b0;
    bus.is_less_i   = 1'b0;
    bus.mem_ready_i = 1'b0;
    rst_ni          = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic run_fetch_decode(input string tag);
    advance(); #1;
    check({tag, " fetch strobes"}, 32'(strobes()), 32'(S_FETCH));
    advance(); #1;
    check({tag, " decode strobes"}, 32'(strobes()), 32'(S_ALUOUT));
  endtask

  task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                            input logic l, input logic exp_taken);
    do_reset();
    bus.opcode_i    = OP_BRANCH;
    bus.funct3_i    = f3;
    bus.is_zero_i   = z;
    bus.is_less_i   = l;
    bus.mem_ready_i = 1'b1;
    run_fetch_decode(tag);
    advance(); #1;
    check({tag, " exec strobes"}, 32'(strobes()), 32'(exp_taken ? S_BRTAKEN : S_NONE));
    check({tag, " exec alu_op"}, 32'(bus.alu_opcode_o), 32'(OP_R));
    if (exp_taken)
      check({tag, " pc_sel"}, 32'(bus.pc_sel_o), 32'(PC_SEL_ALU_OUT_REG));
    advance(); #1;
    check({tag, " next fetch"}, 32'(strobes()), 32'(S_FETCH));
  endtask

  initial begin
    // ADD, zero wait states: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK
    do_reset();
    bus.opcode_i    = OP_R;
    bus.mem_ready_i = 1'b1;
    #1;
    check("reset strobes", 32'(strobes()), 32'(S_NONE));
    check("reset trap", 32'(trap_o), 0);
    check("reset cycle_cnt", cycle_cnt_o, 0);
    check("reset instret", instret_cnt_o, 0);
    advance(); #1;
    check("add fetch strobes", 32'(strobes()), 32'(S_FETCH));
    check("add fetch b_sel", 32'(bus.alu_b_sel_o), 32'(ALU_B_FOUR));
    check("add fetch iord", 32'(bus.iord_o), 0);
    advance(); #1;
    check("add decode strobes", 32'(strobes()), 32'(S_ALUOUT));
    check("add decode a_sel", 32'(bus.alu_a_sel_o), 32'(ALU_A_OLD_PC));
    advance(); #1;
    check("add exec strobes", 32'(strobes()), 32'(S_ALUOUT));
    check("add exec a_sel", 32'(bus.alu_a_sel_o), 32'(ALU_A_RS1));
    check("add exec b_sel", 32'(bus.alu_b_sel_o), 32'(ALU_B_RS2));
    check("add exec alu_op", 32'(bus.alu_opcode_o), 32'(OP_R));
    advance(); #1;
    check("add wb strobes", 32'(strobes()), 32'(S_RFWE));
    check("add wb wb_sel", 32'(bus.wb_sel_o), 32'(WB_ALU_OUT_REG));
    advance(); #1;
    check("add refetch", 32'(strobes()), 32'(S_FETCH));

    // LOAD with three wait cycles in MEM
    do_reset();
    bus.opcode_i    = OP_LOAD;
    bus.mem_ready_i = 1'b1;
    run_fetch_decode("load");
    advance(); #1;
    check("load exec b_sel", 32'(bus.alu_b_sel_o), 32'(ALU_B_IMM));
    check("load exec alu_op", 32'(bus.alu_opcode_o), 32'(OP_LOAD));
    bus.mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      advance(); #1;
      check("load mem wait strobes", 32'(strobes()), 32'(S_MEMRD));
      check("load mem wait iord", 32'(bus.iord_o), 1);
    end
    advance();
    bus.mem_ready_i = 1'b1;
    #1;
    check("load mem ready strobes", 32'(strobes()), 32'(S_MEMRDY));
    check("load mem ready iord", 32'(bus.iord_o), 1);
    advance(); #1;
    check("load memwb strobes", 32'(strobes()), 32'(S_RFWE));
    check("load memwb wb_sel", 32'(bus.wb_sel_o), 32'(WB_MDR));
    advance(); #1;
    check("load refetch", 32'(strobes()), 32'(S_FETCH));
    check("load refetch iord", 32'(bus.iord_o), 0);

    // STORE, zero wait: 4 cycles
    do_reset();
    bus.opcode_i    = OP_STORE;
    bus.mem_ready_i = 1'b1;
    run_fetch_decode("store");
    advance(); #1;
    check("store exec a_sel", 32'(bus.alu_a_sel_o), 32'(ALU_A_RS1));
    advance(); #1;
    check("store mem strobes", 32'(strobes()), 32'(S_MEMWR));
    check("store mem iord", 32'(bus.iord_o), 1);
    advance(); #1;
    check("store refetch", 32'(strobes()), 32'(S_FETCH));

    // Branches
    run_branch("beq taken", F3_BEQ, 1'b1, 1'b0, 1'b1);
    run_branch("beq not", F3_BEQ, 1'b0, 1'b0, 1'b0);
    run_branch("bne taken", F3_BNE, 1'b0, 1'b0, 1'b1);
    run_branch("blt taken", F3_BLT, 1'b0, 1'b1, 1'b1);
    run_branch("bge not", F3_BGE, 1'b0, 1'b1, 1'b0);

    // JAL: link and redirect in EXECUTE
    do_reset();
    bus.opcode_i    = OP_JAL;
    bus.mem_ready_i = 1'b1;
    run_fetch_decode("jal");
    advance(); #1;
    check("jal exec strobes", 32'(strobes()), 32'(S_JAL));
    check("jal wb_sel", 32'(bus.wb_sel_o), 32'(WB_PC));
    check("jal pc_sel", 32'(bus.pc_sel_o), 32'(PC_SEL_ALU_OUT_REG));
    advance(); #1;
    check("jal refetch", 32'(strobes()), 32'(S_FETCH));

    // LUI / AUIPC operand selects
    do_reset();
    bus.opcode_i    = OP_LUI;
    bus.mem_ready_i = 1'b1;
    run_fetch_decode("lui");
    advance(); #1;
    check("lui a_sel", 32'(bus.alu_a_sel_o), 32'(ALU_A_ZERO));
    check("lui b_sel", 32'(bus.alu_b_sel_o), 32'(ALU_B_IMM));
    advance(); #1;
    check("lui wb strobes", 32'(strobes()), 32'(S_RFWE));

    do_reset();
    bus.opcode_i    = OP_AUIPC;
    bus.mem_ready_i = 1'b1;
    run_fetch_decode("auipc");
    advance(); #1;
    check("auipc a_sel", 32'(bus.alu_a_sel_o), 32'(ALU_A_OLD_PC));
    check("auipc alu_op", 32'(bus.alu_opcode_o), 32'(OP_AUIPC));

    // Illegal branch funct3 traps and stays trapped
    do_reset();
    bus.opcode_i    = OP_BRANCH;
    bus.funct3_i    = 3'b010;
    bus.is_zero_i   = 1'b1;
    bus.mem_ready_i = 1'b1;
    run_fetch_decode("bad f3");
    advance(); #1;
    check("bad f3 exec strobes", 32'(strobes()), 32'(S_NONE));
    for (int i = 0; i < 20; i++) begin
      advance();
      bus.mem_ready_i = i[0];
      #1;
      check("trap sticky", 32'(trap_o), 1);
      check("trap strobes", 32'(strobes()), 32'(S_NONE));
    end
    do_reset();
    #1;
    check("trap cleared", 32'(trap_o), 0);

    // Undefined opcode traps after DECODE
    bus.opcode_i    = opcode'(7'h7F);
    bus.mem_ready_i = 1'b1;
    run_fetch_decode("bad op");
    advance(); #1;
    check("bad op trap", 32'(trap_o), 1);
    check("bad op strobes", 32'(strobes()), 32'(S_NONE));

    // Reset during a FETCH wait drops the request without a clock edge
    do_reset();
    bus.opcode_i = OP_R;
    advance(); #1;
    check("fwait strobes", 32'(strobes()), 32'(S_FWAIT));
    advance(); #1;
    check("fwait hold", 32'(strobes()), 32'(S_FWAIT));
    rst_ni = 1'b0;
    #1;
    check("async reset req", 32'(bus.mem_req_o), 0);
    #1;
    rst_ni          = 1'b1;
    bus.mem_ready_i = 1'b1;
    #1;
    check("restart idle", 32'(strobes()), 32'(S_NONE));
    advance(); #1;
    check("restart fetch", 32'(strobes()), 32'(S_FETCH));

    // Ten back-to-back ADDs: 1 IDLE cycle + 10 x 4
    do_reset();
    bus.opcode_i    = OP_R;
    bus.mem_ready_i = 1'b1;
    repeat (41) advance();
    #1;
    check("10 add at fetch", 32'(strobes()), 32'(S_FETCH));
`ifdef MC_PERF_COUNTERS_EN
    check("cycle_cnt 41", cycle_cnt_o, 41);
    check("instret 10", instret_cnt_o, 10);
`else
    check("cycle_cnt tied", cycle_cnt_o, 0);
    check("instret tied", instret_cnt_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
